// File: rtl/map_input_pingpong_buffer.sv
// Ping-pong input sample buffer for the MAP decoder.
// One bank fills from the front end while the other bank is read by the SISO core.
// A read pass runs forward or reverse, and a stored frame can be re-read until it is released.
module map_input_pingpong_buffer #(
    parameter  int DW    = 12,
    parameter  int DEPTH = 6144,
    parameter  int NCH   = 3,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AW:0]       frame_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [NCH*DW-1:0] wr_data,
    output logic              wr_done,
    input  logic              rd_start,
    input  logic              rd_dir,
    input  logic              rd_en,
    output logic              rd_valid,
    output logic [NCH*DW-1:0] rd_data,
    output logic [AW-1:0]     rd_index,
    output logic              rd_last,
    output logic              rd_busy,
    input  logic              rd_release,
    output logic [1:0]        bank_full,
    output logic              len_err
);
    localparam int W = NCH * DW;

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_t;

    bank_t         bank     [2];
    bank_t         bank_nxt [2];
    logic [AW:0]   blen     [2];
    logic          wb, rb;
    logic [AW-1:0] wcnt, raddr;
    logic          rdir, busy, data_ok;
    logic [W-1:0]  mem0 [DEPTH];
    logic [W-1:0]  mem1 [DEPTH];
    logic [W-1:0]  rq;

    logic          wb_empty, len_ok, wr_acc, wr_final;
    logic [AW:0]   cur_len;
    logic          start_acc, issue, rd_final, rel_acc;

    // Write/read qualifiers; the length of a frame still EMPTY comes straight from frame_len
    always_comb begin
        wb_empty  = (bank[wb] == EMPTY);
        len_ok    = (frame_len != '0) && (frame_len <= (AW+1)'(DEPTH));
        len_err   = wb_empty & ~len_ok;
        wr_ready  = (bank[wb] == FILLING) | (wb_empty & len_ok);
        wr_acc    = wr_valid & wr_ready;
        cur_len   = wb_empty ? frame_len : blen[wb];
        wr_final  = wr_acc & ({1'b0, wcnt} == cur_len - 1'b1);
        start_acc = rd_start & (bank[rb] == FULL) & ~busy;
        issue     = busy & rd_en;
        rd_final  = issue & (rdir ? (raddr == '0) : ({1'b0, raddr} == blen[rb] - 1'b1));
        // a start in the same cycle takes priority over a release
        rel_acc   = rd_release & (bank[rb] == FULL) & ~busy & ~start_acc;
    end

    // Per-bank next state: write events only touch EMPTY/FILLING, read events only FULL/READING
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bank_nxt[i] = bank[i];
            if (wr_acc && wb == 1'(i))
                bank_nxt[i] = wr_final ? FULL : FILLING;
            if (rb == 1'(i)) begin
                if (start_acc)     bank_nxt[i] = READING;
                else if (rel_acc)  bank_nxt[i] = EMPTY;
                else if (rd_final) bank_nxt[i] = FULL;
            end
        end
    end

    // Bank states, write pointer/counter, latched frame lengths, read-bank pointer
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank[0] <= EMPTY;
            bank[1] <= EMPTY;
            blen[0] <= '0;
            blen[1] <= '0;
            wb      <= 1'b0;
            rb      <= 1'b0;
            wcnt    <= '0;
            wr_done <= 1'b0;
        end else begin
            bank[0] <= bank_nxt[0];
            bank[1] <= bank_nxt[1];
            wr_done <= wr_final;
            if (wr_acc) begin
                if (wb_empty) blen[wb] <= frame_len;
                if (wr_final) begin
                    wcnt <= '0;
                    wb   <= ~wb;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (rel_acc) rb <= ~rb;
        end
    end

    // Read pass sequencing: address generation and output qualifiers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            rdir     <= 1'b0;
            raddr    <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_index <= '0;
            data_ok  <= 1'b0;
        end else begin
            rd_valid <= issue;
            rd_last  <= rd_final;
            if (start_acc) begin
                busy  <= 1'b1;
                rdir  <= rd_dir;
                raddr <= rd_dir ? AW'(blen[rb] - 1'b1) : '0;
            end else if (issue) begin
                raddr <= rdir ? raddr - 1'b1 : raddr + 1'b1;
                if (rd_final) busy <= 1'b0;
            end
            if (issue) begin
                rd_index <= raddr;
                data_ok  <= 1'b1;
            end
        end
    end

    // Bank 0 RAM write port
    always_ff @(posedge clock) begin
        if (wr_acc && !wb) mem0[wcnt] <= wr_data;
    end

    // Bank 1 RAM write port
    always_ff @(posedge clock) begin
        if (wr_acc && wb) mem1[wcnt] <= wr_data;
    end

    // Registered read; holds its value between issues
    always_ff @(posedge clock) begin
        if (issue) rq <= rb ? mem1[raddr] : mem0[raddr];
    end

    // RAM output register has no reset, so gate it to zero until the first issue after reset
    assign rd_data   = data_ok ? rq : '0;
    assign rd_busy   = busy;
    assign bank_full = {(bank[1] == FULL) || (bank[1] == READING),
                        (bank[0] == FULL) || (bank[0] == READING)};

endmodule
